// File: rtl/conv_tile_scheduler_if.sv
`default_nettype none
// conv_tile_scheduler_if: host-control and MemoryController handshake bundle for the tile scheduler.
// master = scheduler side, slave = host/controller side.
interface conv_tile_scheduler_if #(
  parameter int W_ADDR_BIT     = 11,
  parameter int OFMAP_ADDR_BIT = 10,
  parameter int TILE_NUM       = 4
);
  localparam int IDX_BIT = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

  logic                      layer_start_in;
  logic                      layer_abort_in;
  logic                      host_drain_en_in;
  logic                      mc_mac_done_in;
  logic                      mc_ofmap_write_en_in;
  logic                      mc_ofmap_write_done_in;
  logic                      mc_start_out;
  logic                      mc_ofmap_ready_out;
  logic [W_ADDR_BIT-1:0]     w_base_addr_out;
  logic [OFMAP_ADDR_BIT-1:0] ofmap_base_addr_out;
  logic [IDX_BIT-1:0]        tile_idx_out;
  logic                      busy_out;
  logic                      layer_done_out;
  logic                      err_out;

  modport master (
    input  layer_start_in, layer_abort_in, host_drain_en_in,
           mc_mac_done_in, mc_ofmap_write_en_in, mc_ofmap_write_done_in,
    output mc_start_out, mc_ofmap_ready_out, w_base_addr_out, ofmap_base_addr_out,
           tile_idx_out, busy_out, layer_done_out, err_out
  );

  modport slave (
    output layer_start_in, layer_abort_in, host_drain_en_in,
           mc_mac_done_in, mc_ofmap_write_en_in, mc_ofmap_write_done_in,
    input  mc_start_out, mc_ofmap_ready_out, w_base_addr_out, ofmap_base_addr_out,
           tile_idx_out, busy_out, layer_done_out, err_out
  );
endinterface
`default_nettype wire

// File: rtl/conv_tile_scheduler.sv
`default_nettype none
// conv_tile_scheduler: steps the MemoryController through every output-channel tile of a
// layer, handing out per-tile base addresses and checking the ofmap writeback word count.
module conv_tile_scheduler #(
  parameter int TILE_NUM         = 4,
  parameter int W_TILE_WORDS     = 288,
  parameter int OFMAP_TILE_WORDS = 196,
  parameter int W_ADDR_BIT       = 11,
  parameter int OFMAP_ADDR_BIT   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_tile_scheduler_if.master bus
);
  localparam int                      IDX_BIT      = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;
  localparam logic [IDX_BIT-1:0]      LAST_TILE    = IDX_BIT'(TILE_NUM - 1);
  localparam logic [15:0]             TILE_WORDS16 = 16'(OFMAP_TILE_WORDS);
  localparam logic [W_ADDR_BIT-1:0]   W_STEP       = W_ADDR_BIT'(W_TILE_WORDS);
  localparam logic [OFMAP_ADDR_BIT-1:0] O_STEP     = OFMAP_ADDR_BIT'(OFMAP_TILE_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    NEXT    = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                    state;
  logic                      mc_start;
  logic                      busy;
  logic                      layer_done;
  logic                      err;
  logic [IDX_BIT-1:0]        tile_idx;
  logic [W_ADDR_BIT-1:0]     w_base;
  logic [OFMAP_ADDR_BIT-1:0] ofmap_base;
  logic [15:0]               wr_cnt;
  logic [15:0]               wr_cnt_upd;

  // Count including this cycle's strobe, so a write_en alongside write_done is not lost
  always_comb begin
    wr_cnt_upd = wr_cnt;
    if (bus.mc_ofmap_write_en_in && (wr_cnt != 16'hFFFF)) begin
      wr_cnt_upd = wr_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mc_start   <= 1'b0;
      busy       <= 1'b0;
      layer_done <= 1'b0;
      err        <= 1'b0;
      tile_idx   <= '0;
      w_base     <= '0;
      ofmap_base <= '0;
      wr_cnt     <= '0;
    end else begin
      mc_start   <= 1'b0;
      layer_done <= 1'b0;
      if (bus.mc_ofmap_write_en_in && (state != DRAIN)) begin
        err <= 1'b1;
      end
      if (bus.layer_abort_in && (state != IDLE)) begin
        state      <= IDLE;
        busy       <= 1'b0;
        tile_idx   <= '0;
        w_base     <= '0;
        ofmap_base <= '0;
        wr_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.layer_start_in && !bus.layer_abort_in) begin
              state      <= START;
              mc_start   <= 1'b1;
              busy       <= 1'b1;
              err        <= 1'b0;
              tile_idx   <= '0;
              w_base     <= '0;
              ofmap_base <= '0;
              wr_cnt     <= '0;
            end
          end
          START: state <= COMPUTE;
          COMPUTE: begin
            if (bus.mc_mac_done_in) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            wr_cnt <= wr_cnt_upd;
            if (bus.mc_ofmap_write_done_in) begin
              state <= NEXT;
              if (wr_cnt_upd != TILE_WORDS16) begin
                err <= 1'b1;
              end
            end
          end
          NEXT: begin
            wr_cnt <= '0;
            if (tile_idx == LAST_TILE) begin
              state      <= DONE;
              layer_done <= 1'b1;
            end else begin
              state      <= START;
              mc_start   <= 1'b1;
              tile_idx   <= tile_idx + 1'b1;
              w_base     <= w_base + W_STEP;
              ofmap_base <= ofmap_base + O_STEP;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.mc_start_out        = mc_start;
  assign bus.mc_ofmap_ready_out  = (state == DRAIN) && bus.host_drain_en_in;
  assign bus.w_base_addr_out     = w_base;
  assign bus.ofmap_base_addr_out = ofmap_base;
  assign bus.tile_idx_out        = tile_idx;
  assign bus.busy_out            = busy;
  assign bus.layer_done_out      = layer_done;
  assign bus.err_out             = err;
endmodule
`default_nettype wire

// File: tb/tb_conv_tile_scheduler.sv
`default_nettype none
// tb_conv_tile_scheduler: randomized MemoryController/host model driving whole layers,
// with per-scenario checks against tile arithmetic and handshake timing rules.
module tb_conv_tile_scheduler;
  localparam int TILE_NUM         = 4;
  localparam int W_TILE_WORDS     = 288;
  localparam int OFMAP_TILE_WORDS = 196;
  localparam int W_ADDR_BIT       = 11;
  localparam int OFMAP_ADDR_BIT   = 10;
  localparam int MAX_CYC          = 8000;
  localparam int PH_IDLE = 0, PH_COMPUTE = 1, PH_DRAIN = 2, PH_NEXT = 3, PH_POST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_tile_scheduler_if #(.W_ADDR_BIT(W_ADDR_BIT), .OFMAP_ADDR_BIT(OFMAP_ADDR_BIT), .TILE_NUM(TILE_NUM)) bus_if ();

  conv_tile_scheduler #(
    .TILE_NUM(TILE_NUM), .W_TILE_WORDS(W_TILE_WORDS), .OFMAP_TILE_WORDS(OFMAP_TILE_WORDS),
    .W_ADDR_BIT(W_ADDR_BIT), .OFMAP_ADDR_BIT(OFMAP_ADDR_BIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  int checks = 0;
  int errors = 0;
  int n_start, n_done, ready_bad, gap_bad, busy_bad, err_early, err_after, err_hold_bad;
  int err_at_done, err_first_start, busy_after, done_after;
  bit timed_out, aborted;
  int w_q[$];
  int o_q[$];
  int t_q[$];

  task automatic clear_inputs();
    bus_if.layer_start_in         = 1'b0;
    bus_if.layer_abort_in         = 1'b0;
    bus_if.host_drain_en_in       = 1'b0;
    bus_if.mc_mac_done_in         = 1'b0;
    bus_if.mc_ofmap_write_en_in   = 1'b0;
    bus_if.mc_ofmap_write_done_in = 1'b0;
  endtask

  // One layer: host start at cycle 0, then a controller model reacting to the scheduler.
  task automatic drive_layer(input int short_tile, input bit bp, input int busy_tile, input int abort_tile);
    int  phase = PH_IDLE;
    int  cur, wait_c = 0, words_left = 0, dcyc = 0, last_wd = -100, short_wd = -1, cyc = 0;
    bit  fin = 1'b0, busy_pulsed = 1'b0, we, wd;
    n_start = 0; n_done = 0; ready_bad = 0; gap_bad = 0; busy_bad = 0; err_early = 0;
    err_after = -1; err_hold_bad = 0; err_at_done = -1; err_first_start = -1;
    busy_after = -1; done_after = -1; timed_out = 1'b0; aborted = 1'b0;
    w_q.delete(); o_q.delete(); t_q.delete();
    while (!fin && cyc < MAX_CYC) begin
      @(negedge clk);
      cur = phase;
      clear_inputs();
      bus_if.layer_start_in   = (cyc == 0);
      bus_if.host_drain_en_in = 1'($urandom_range(0, 1));
      if (cur == PH_DRAIN) begin
        bus_if.host_drain_en_in = bp ? (((dcyc / 3) % 2) == 0) : 1'b1;
        bus_if.mc_mac_done_in   = ($urandom_range(0, 4) == 0);
      end
      if (cur == PH_COMPUTE) begin
        if (wait_c == 0) begin
          bus_if.mc_mac_done_in = 1'b1;
          phase      = PH_DRAIN;
          words_left = (n_start - 1 == short_tile) ? OFMAP_TILE_WORDS - 1 : OFMAP_TILE_WORDS;
          dcyc       = 0;
        end else begin
          wait_c--;
        end
        if (n_start - 1 == busy_tile && !busy_pulsed) begin
          bus_if.layer_start_in = 1'b1;
          busy_pulsed = 1'b1;
        end
      end
      #1;
      if (bus_if.mc_ofmap_ready_out !== ((cur == PH_DRAIN) && bus_if.host_drain_en_in)) ready_bad++;
      if (cyc > 0 && (short_wd < 0 || cyc <= short_wd) && bus_if.err_out !== 1'b0) err_early++;
      if (short_wd >= 0 && cyc == short_wd + 1) err_after = int'(bus_if.err_out);
      if (short_wd >= 0 && cyc > short_wd && cur != PH_POST && bus_if.err_out !== 1'b1) err_hold_bad++;
      if (n_start > 0 && cur != PH_POST && bus_if.busy_out !== 1'b1) busy_bad++;
      if (cur == PH_POST) begin
        busy_after = int'(bus_if.busy_out);
        done_after = int'(bus_if.layer_done_out);
        fin = 1'b1;
      end
      if (cur == PH_DRAIN) begin
        if (n_start - 1 == abort_tile && dcyc == 2) begin
          bus_if.layer_abort_in = 1'b1;
          aborted = 1'b1;
          fin     = 1'b1;
        end else begin
          we = bus_if.mc_ofmap_ready_out && (words_left > 0) && ($urandom_range(0, 3) != 0);
          if (we) words_left--;
          wd = (words_left == 0) && (!we || $urandom_range(0, 1) == 1);
          bus_if.mc_ofmap_write_en_in   = we;
          bus_if.mc_ofmap_write_done_in = wd;
          if (wd) begin
            last_wd = cyc;
            if (n_start - 1 == short_tile) short_wd = cyc;
            phase = PH_NEXT;
          end
          dcyc++;
        end
      end
      if (bus_if.mc_start_out === 1'b1) begin
        n_start++;
        w_q.push_back(int'(bus_if.w_base_addr_out));
        o_q.push_back(int'(bus_if.ofmap_base_addr_out));
        t_q.push_back(int'(bus_if.tile_idx_out));
        if (n_start == 1) begin
          err_first_start = int'(bus_if.err_out);
          if (cyc != 1) gap_bad++;
        end else if (cyc != last_wd + 2) begin
          gap_bad++;
        end
        phase  = PH_COMPUTE;
        wait_c = $urandom_range(0, 5);
      end
      if (bus_if.layer_done_out === 1'b1) begin
        n_done++;
        err_at_done = int'(bus_if.err_out);
        if (cyc != last_wd + 2) gap_bad++;
        phase = PH_POST;
      end
      cyc++;
    end
    if (!fin) timed_out = 1'b1;
    if (!aborted) clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({bus_if.mc_start_out, bus_if.mc_ofmap_ready_out, bus_if.w_base_addr_out, bus_if.ofmap_base_addr_out,
         bus_if.tile_idx_out, bus_if.busy_out, bus_if.layer_done_out, bus_if.err_out} !== '0) begin
      errors++; $display("FAIL reset_outputs: busy=%0b err=%0b start=%0b required all zero",
                         bus_if.busy_out, bus_if.err_out, bus_if.mc_start_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_layer();
    int ew, eo, gw, go, gt;
    drive_layer(-1, 1'b0, -1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL full_timeout: got 1 required 0"); end
    checks++; if (n_start != TILE_NUM) begin errors++; $display("FAIL full_starts: got %0d required %0d", n_start, TILE_NUM); end
    for (int i = 0; i < TILE_NUM; i++) begin
      ew = (i * W_TILE_WORDS) % (1 << W_ADDR_BIT);
      eo = (i * OFMAP_TILE_WORDS) % (1 << OFMAP_ADDR_BIT);
      gw = (i < w_q.size()) ? w_q[i] : -1;
      go = (i < o_q.size()) ? o_q[i] : -1;
      gt = (i < t_q.size()) ? t_q[i] : -1;
      checks++;
      if (gw != ew || go != eo || gt != i) begin
        errors++; $display("FAIL full_tile%0d: got w=%0d o=%0d idx=%0d required w=%0d o=%0d idx=%0d", i, gw, go, gt, ew, eo, i);
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL full_done_pulses: got %0d required 1", n_done); end
    checks++; if (err_at_done != 0 || err_early != 0) begin errors++; $display("FAIL full_err: got done=%0d early=%0d required 0", err_at_done, err_early); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL full_ready: got %0d bad cycles required 0", ready_bad); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL full_latency: got %0d bad events required 0", gap_bad); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL full_busy: got %0d low cycles required 0", busy_bad); end
    checks++; if (busy_after != 0 || done_after != 0) begin errors++; $display("FAIL full_after_done: got busy=%0d done=%0d required 0", busy_after, done_after); end
  endtask

  task automatic test_backpressure();
    drive_layer(-1, 1'b1, -1, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: got 1 required 0"); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL bp_ready_follow: got %0d bad cycles required 0", ready_bad); end
    checks++; if (n_start != TILE_NUM || n_done != 1) begin errors++; $display("FAIL bp_sequence: got starts=%0d done=%0d required %0d 1", n_start, n_done, TILE_NUM); end
    checks++; if (err_at_done != 0) begin errors++; $display("FAIL bp_err: got %0d required 0", err_at_done); end
  endtask

  task automatic test_count_error();
    drive_layer(2, 1'b0, -1, -1);
    checks++; if (err_early != 0) begin errors++; $display("FAIL cnt_err_early: got %0d cycles high required 0", err_early); end
    checks++; if (err_after != 1) begin errors++; $display("FAIL cnt_err_set: got %0d required 1", err_after); end
    checks++; if (err_hold_bad != 0 || err_at_done != 1) begin errors++; $display("FAIL cnt_err_hold: got drops=%0d at_done=%0d required 0 1", err_hold_bad, err_at_done); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL cnt_done: got %0d required 1", n_done); end
    drive_layer(-1, 1'b0, -1, -1);
    checks++; if (err_first_start != 0 || err_at_done != 0) begin errors++; $display("FAIL cnt_err_clear: got start=%0d done=%0d required 0", err_first_start, err_at_done); end
  endtask

  task automatic test_start_while_busy();
    drive_layer(-1, 1'b0, 1, -1);
    checks++; if (n_start != TILE_NUM) begin errors++; $display("FAIL busy_start_starts: got %0d required %0d", n_start, TILE_NUM); end
    checks++; if (n_done != 1 || gap_bad != 0) begin errors++; $display("FAIL busy_start_done: got done=%0d gap=%0d required 1 0", n_done, gap_bad); end
  endtask

  task automatic test_abort();
    int bad = 0;
    drive_layer(-1, 1'b0, -1, TILE_NUM - 1);
    checks++; if (!aborted || n_start != TILE_NUM) begin errors++; $display("FAIL abort_reached: got aborted=%0d starts=%0d required 1 %0d", aborted, n_start, TILE_NUM); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ({bus_if.busy_out, bus_if.tile_idx_out, bus_if.w_base_addr_out, bus_if.ofmap_base_addr_out,
         bus_if.layer_done_out, bus_if.mc_start_out, bus_if.mc_ofmap_ready_out} !== '0) begin
      errors++; $display("FAIL abort_outputs: got busy=%0b idx=%0d w=%0d o=%0d done=%0b required all zero",
                         bus_if.busy_out, bus_if.tile_idx_out, bus_if.w_base_addr_out, bus_if.ofmap_base_addr_out, bus_if.layer_done_out);
    end
    repeat (5) begin
      @(negedge clk); #1;
      if (bus_if.layer_done_out !== 1'b0 || bus_if.busy_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", bad); end
    drive_layer(-1, 1'b0, -1, -1);
    checks++; if (n_start != TILE_NUM || n_done != 1 || gap_bad != 0) begin errors++; $display("FAIL abort_rerun: got starts=%0d done=%0d gap=%0d required %0d 1 0", n_start, n_done, gap_bad, TILE_NUM); end
    checks++; if (w_q.size() != TILE_NUM || w_q[TILE_NUM-1] != 864 || o_q[TILE_NUM-1] != 588) begin errors++; $display("FAIL abort_rerun_bases: got %0d entries required last w=864 o=588", w_q.size()); end
  endtask

  task automatic test_stray_write();
    @(negedge clk);
    clear_inputs();
    bus_if.mc_ofmap_write_en_in = 1'b1;
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (bus_if.err_out !== 1'b1 || bus_if.busy_out !== 1'b0) begin errors++; $display("FAIL stray_write: got err=%0b busy=%0b required 1 0", bus_if.err_out, bus_if.busy_out); end
    drive_layer(-1, 1'b0, -1, -1);
    checks++; if (err_first_start != 0 || err_at_done != 0) begin errors++; $display("FAIL stray_clear: got start=%0d done=%0d required 0", err_first_start, err_at_done); end
  endtask

  task automatic test_async_reset();
    int bad = 0;
    @(negedge clk); clear_inputs(); bus_if.layer_start_in = 1'b1;
    @(negedge clk); bus_if.layer_start_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus_if.busy_out !== 1'b1) begin errors++; $display("FAIL arst_pre_busy: got %0b required 1", bus_if.busy_out); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus_if.mc_start_out, bus_if.mc_ofmap_ready_out, bus_if.w_base_addr_out, bus_if.ofmap_base_addr_out,
         bus_if.tile_idx_out, bus_if.busy_out, bus_if.layer_done_out, bus_if.err_out} !== '0) begin
      errors++; $display("FAIL arst_immediate: got busy=%0b required all zero", bus_if.busy_out);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) begin
      @(negedge clk); #1;
      if (bus_if.busy_out !== 1'b0 || bus_if.mc_start_out !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL arst_stays_idle: got %0d active cycles required 0", bad); end
    drive_layer(-1, 1'b0, -1, -1);
    checks++; if (n_start != TILE_NUM || n_done != 1 || timed_out) begin errors++; $display("FAIL arst_rerun: got starts=%0d done=%0d required %0d 1", n_start, n_done, TILE_NUM); end
  endtask

  initial begin
    test_reset();
    test_full_layer();
    test_backpressure();
    test_count_error();
    test_start_while_busy();
    test_abort();
    test_stray_write();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Layer-level sequencer that drives the MemoryController across all output-channel tiles of one convolution layer. Per tile it pulses the controller's start, waits for MAC completion, and opens ofmap writeback when the host-side drain path allows it. It also supplies per-tile weight and ofmap base addresses and checks the writeback word count. It sits between the top-level host control registers and the MemoryController start/ready/done handshake.

## Interface
- TILE_NUM, 4: output-channel tiles per layer (OFMAP_CHANNEL_NUM/MAC_COL); must be ≥1.
- W_TILE_WORDS, 288: weight RAM words consumed per tile.
- OFMAP_TILE_WORDS, 196: ofmap RAM words written per tile.
- W_ADDR_BIT, 11: weight address width.
- OFMAP_ADDR_BIT, 10: ofmap address width.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- layer_start_in  in  1  one-cycle request to run a layer; honoured only in IDLE.
- layer_abort_in  in  1  abort the current layer; overrides all other inputs.
- host_drain_en_in  in  1  host can accept ofmap writeback this cycle.
- mc_mac_done_in  in  1  MemoryController mac_done.
- mc_ofmap_write_en_in  in  1  MemoryController ofmap write strobe.
- mc_ofmap_write_done_in  in  1  MemoryController ofmap_write_done.
- mc_start_out  out  1  one-cycle start pulse to the MemoryController.
- mc_ofmap_ready_out  out  1  ofmap_ready to the MemoryController.
- w_base_addr_out  out  W_ADDR_BIT  weight base address of the current tile.
- ofmap_base_addr_out  out  OFMAP_ADDR_BIT  ofmap base address of the current tile.
- tile_idx_out  out  max(1,$clog2(TILE_NUM))  current tile index.
- busy_out  out  1  high in every state except IDLE.
- layer_done_out  out  1  one-cycle pulse after the last tile drains.
- err_out  out  1  sticky writeback-count error.

## Operation
- FSM states: IDLE, START, COMPUTE, DRAIN, NEXT, DONE.
- IDLE: on layer_start_in, go to START. Clear tile_idx, both base addresses, write counter and err_out.
- START: lasts 1 cycle, with mc_start_out=1. Go to COMPUTE.
- COMPUTE: wait for mc_mac_done_in=1, then go to DRAIN. mac_done is ignored in all other states.
- DRAIN:
  - mc_ofmap_ready_out = host_drain_en_in. This is a combinational AND with the state decode; all other outputs are registered.
  - Each mc_ofmap_write_en_in increments the 16-bit saturating write counter.
  - On mc_ofmap_write_done_in, go to NEXT. If the final count, including any write_en in the same cycle, is not OFMAP_TILE_WORDS, set err_out.
- NEXT: lasts 1 cycle and clears the write counter.
  - If tile_idx == TILE_NUM-1, go to DONE.
  - Otherwise increment tile_idx, add W_TILE_WORDS to w_base_addr_out, add OFMAP_TILE_WORDS to ofmap_base_addr_out, and go to START.
  - Address adds wrap modulo 2^W_ADDR_BIT and 2^OFMAP_ADDR_BIT; no saturation or flag.
- DONE: lasts 1 cycle, with layer_done_out=1. Go to IDLE. tile_idx and the base addresses hold their last values until the next accepted start.
- mc_ofmap_write_en_in outside DRAIN sets err_out and is not counted.
- err_out does not stop the sequence. It clears only on reset or an accepted layer_start_in.
- layer_start_in while busy is ignored, with no queuing.
- layer_abort_in in any non-IDLE state: go to IDLE next cycle, with no layer_done_out pulse. err_out is retained; the counter, tile_idx and base addresses clear.
- layer_abort_in in IDLE has no effect. Abort wins over a simultaneous start.

## Timing
- Reset (async assert, sync release):
  - State is IDLE.
  - All outputs are 0, and mc_ofmap_ready_out=0 because the state is IDLE.
- Cycle 0: layer_start_in sampled high. Cycle 1: mc_start_out=1 and busy_out=1. Cycle 2: COMPUTE.
- mc_mac_done_in sampled at cycle k gives DRAIN at k+1; mc_ofmap_ready_out can be high from k+1.
- mc_ofmap_write_done_in sampled at cycle m gives NEXT at m+1. The next tile's START, and its mc_start_out, is at m+2, with updated base addresses and tile_idx already visible in that cycle.
- Fixed overhead per tile is 3 cycles: START, the COMPUTE entry, and NEXT.
- After the last tile's write_done at cycle m: DONE and layer_done_out at m+2, busy_out=0 at m+3.
- Abort sampled at cycle a gives busy_out=0 and all outputs 0 at a+1.

## Test plan
- Full layer with TILE_NUM=4, host_drain_en_in=1, and a model controller writing 196 words per tile:
  - Exactly 4 mc_start_out pulses.
  - w_base sequence 0, 288, 576, 864; ofmap_base sequence 0, 196, 392, 588.
  - One layer_done_out pulse and err_out=0.
- Backpressure: toggle host_drain_en_in 1/0 every 3 cycles in DRAIN.
  - mc_ofmap_ready_out follows it in the same cycle.
  - The sequence completes with err_out=0.
- Count error: the model writes 195 words on tile 2, then write_done.
  - err_out=1 from the cycle after write_done, and stays high through layer_done_out.
  - It clears on the next layer_start_in.
- Start while busy: pulse layer_start_in in COMPUTE of tile 1.
  - Ignored: still exactly 4 starts and 1 layer_done_out.
- Abort: assert layer_abort_in in DRAIN of tile 3.
  - Next cycle busy_out=0, tile_idx_out=0, both bases 0, and no layer_done_out.
  - A new layer_start_in then runs a clean 4-tile sequence.
- Async reset mid-COMPUTE (rst asserted between clock edges):
  - All outputs go to 0 immediately.
  - After release, the block stays in IDLE until layer_start_in.
